// File: rtl/coord_frame_if.sv
// Coordinate frame parser bus: byte stream in, committed coordinate set out.
// master = byte source / display consumer, slave = parser.
interface coord_frame_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] x1, y1, z1, x2, y2, z2;
  logic        frame_valid;
  logic        frame_error;
  logic [7:0]  frame_cnt;

  modport master (
    output rx_data, rx_valid,
    input  x1, y1, z1, x2, y2, z2, frame_valid, frame_error, frame_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output x1, y1, z1, x2, y2, z2, frame_valid, frame_error, frame_cnt
  );
endinterface

// File: rtl/coord_frame_parser.sv
// Coordinate frame parser: SYNC_BYTE followed by 12 big-endian bytes
// (x1,y1,z1,x2,y2,z2), committed atomically to registered outputs.
// Optional trailing 8-bit modulo checksum byte: macro COORD_FRAME_CHECKSUM_EN.
module coord_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input logic          clock,
  input logic          reset,
  coord_frame_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA
`ifdef COORD_FRAME_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [TW-1:0]     r_tmo;
  logic [11:0][7:0]  r_shadow;
  logic [5:0][15:0]  r_coord;
  logic              r_frame_valid;
  logic              r_frame_error;
  logic [7:0]        r_frame_cnt;
`ifdef COORD_FRAME_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic [11:0][7:0]  w_buf;
  logic              w_tmo_hit;
  logic              w_commit;
  logic              w_error;

  // Shadow contents including the byte being sampled now, so a commit on the
  // final byte can load the outputs in the same edge.
  always_comb begin
    w_buf     = r_shadow;
    if (r_state == DATA && bus.rx_valid) w_buf[r_idx] = bus.rx_data;
    w_tmo_hit = (r_state != IDLE) && !bus.rx_valid && (r_tmo == TMO_LAST);
`ifdef COORD_FRAME_CHECKSUM_EN
    w_commit  = (r_state == CHK) && bus.rx_valid && (bus.rx_data == r_sum);
    w_error   = w_tmo_hit || ((r_state == CHK) && bus.rx_valid && (bus.rx_data != r_sum));
`else
    w_commit  = (r_state == DATA) && bus.rx_valid && (r_idx == 4'd11);
    w_error   = w_tmo_hit;
`endif
  end

  // Frame FSM, shadow capture, timeout and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_tmo         <= '0;
      r_shadow      <= '0;
      r_coord       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_cnt   <= '0;
`ifdef COORD_FRAME_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_frame_valid <= w_commit;
      r_frame_error <= w_error;
      r_shadow      <= w_buf;
      // Idle cycles are only counted inside a frame; any accepted byte restarts it.
      r_tmo         <= (r_state == IDLE || bus.rx_valid || w_tmo_hit) ? '0 : r_tmo + TW'(1);
      if (w_commit) begin
        for (int i = 0; i < 6; i++) r_coord[i] <= {w_buf[2*i], w_buf[2*i+1]};
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      case (r_state)
        IDLE: begin
          r_idx <= '0;
`ifdef COORD_FRAME_CHECKSUM_EN
          r_sum <= '0;
`endif
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) r_state <= DATA;
        end
        DATA: begin
          if (w_tmo_hit) begin
            r_state <= IDLE;
          end else if (bus.rx_valid) begin
            r_idx <= r_idx + 4'd1;
`ifdef COORD_FRAME_CHECKSUM_EN
            r_sum <= r_sum + bus.rx_data;
            if (r_idx == 4'd11) r_state <= CHK;
`else
            if (r_idx == 4'd11) r_state <= IDLE;
`endif
          end
        end
`ifdef COORD_FRAME_CHECKSUM_EN
        CHK: begin
          if (w_tmo_hit || bus.rx_valid) r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.x1          = r_coord[0];
  assign bus.y1          = r_coord[1];
  assign bus.z1          = r_coord[2];
  assign bus.x2          = r_coord[3];
  assign bus.y2          = r_coord[4];
  assign bus.z2          = r_coord[5];
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule
